window_scan_ctrl: RTL and testbench
===================================

// Module: window_scan_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 slidingWindow line-buffer datapath feeding the Sobel stage.
//  - Accepts a raster pixel stream and forwards each pixel to the window with a shift strobe.
//  - Tracks row/column and flags which window positions are valid; border and row-wrap windows are suppressed.
//  - Applies downstream backpressure and brackets each frame with start / clear / done.
// PARAMETERS
//  WORD_SIZE    8   pixel width in bits
//  ROW_SIZE     10  pixels per row
//  NUM_ROWS     10  rows per frame
//  BUFFER_SIZE  3   window edge length; odd, >=3, <=ROW_SIZE and <=NUM_ROWS
// PORTS
//  clk          in   1                      system clock, single domain
//  reset        in   1                      synchronous, active-high
//  start        in   1                      begin a frame; honoured in IDLE only
//  in_valid     in   1                      upstream pixel valid
//  in_ready     out  1                      controller can accept the pixel
//  in_pixel     in   WORD_SIZE              upstream pixel
//  px_out       out  WORD_SIZE              pixel to window = in_pixel (combinational)
//  shift_en     out  1                      window/line-buffer advance = in_valid & in_ready
//  clear_window out  1                      1-cycle pulse; resets window and line-buffer pointer
//  out_ready    in   1                      downstream Sobel stage accepts the current window
//  win_valid    out  1                      window registers hold a complete, valid window
//  win_row      out  $clog2(NUM_ROWS)       row of window centre
//  win_col      out  $clog2(ROW_SIZE)       column of window centre
//  busy         out  1                      state != IDLE
//  frame_done   out  1                      1-cycle pulse at end of frame
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; row/col counters 0.
//  States and transitions:
//  - IDLE->FILL on start; clear_window pulses in the first FILL cycle.
//  - FILL->RUN on accept of the first qualifying pixel.
//  - RUN->DONE on accept of pixel (NUM_ROWS-1, ROW_SIZE-1).
//  - DONE->IDLE once win_valid=0; frame_done pulses on that transition.
//  Handshake:
//  - in_ready = (state is FILL or RUN) & !clear_window & (!win_valid | out_ready).
//  - accept = in_valid & in_ready. Counters and shift_en act only on accept.
//  Counters give the position of the pixel being accepted:
//  - col wraps ROW_SIZE-1 -> 0, and row increments on that wrap.
//  - row is not wrapped inside a frame. Both reset to 0 on start.
//  Qualifying pixel: row >= BUFFER_SIZE-1 and col >= BUFFER_SIZE-1.
//  - This suppresses windows that straddle a row wrap.
//  - Valid windows per frame = (ROW_SIZE-BUFFER_SIZE+1)*(NUM_ROWS-BUFFER_SIZE+1).
//  Window output (latency 1 cycle, matching the window register):
//  - win_valid is set the cycle after a qualifying accept.
//  - win_valid holds while out_ready=0.
//  - win_valid clears after out_ready=1 unless a new qualifying accept occurs in the same cycle.
//  - win_row = row-(BUFFER_SIZE-1)/2 and win_col = col-(BUFFER_SIZE-1)/2, registered with win_valid.
//  - win_row/win_col are stable while win_valid=1 and out_ready=0.
//  - Consume and accept in the same cycle: the new window replaces the old one; no bubble.
//  Boundaries:
//  - start outside IDLE is ignored.
//  - in_valid in IDLE or DONE is not accepted (in_ready=0).
//  - Mid-frame reset aborts the frame: IDLE, win_valid=0, no frame_done pulse.
//  - A pending window at the last pixel is held until consumed before DONE->IDLE.
// STRUCTURE
//  Package window_ctrl_pkg holds:
//  - ctrl_state_t enum {IDLE, FILL, RUN, DONE};
//  - localparams for the row/col counter widths and the window-centre offset (BUFFER_SIZE-1)/2.
//  Sub-module mod_counter #(MAX) (clk, reset, clr, en, count, wrap): used twice, for col and row.
//  The FSM and the win_valid/win_row/win_col registers stay in this module.
//  The module holds no pixel storage.
// TESTING (ROW_SIZE=10, NUM_ROWS=10, BUFFER_SIZE=3, out_ready=1 unless stated)
//  1 Reset then start with in_valid=1 continuous:
//    -> clear_window pulses once;
//    -> first win_valid appears 1 cycle after pixel #22 (r2,c2), with win_row=1, win_col=1;
//    -> 64 windows total; frame_done pulses once; busy returns 0.
//  2 Row wrap: accepting pixels (r3,c0) and (r3,c1) produces no win_valid;
//    pixel (r3,c2) yields win_valid with win_row=2, win_col=1.
//  3 Hold out_ready=0 for 5 cycles while win_valid=1:
//    -> in_ready=0 and shift_en=0 throughout; win_row/win_col unchanged; no window lost or duplicated.
//  4 Pulse start in mid-RUN and during DONE:
//    -> ignored; counters keep counting; still exactly 64 windows.
//  5 Assert reset after 40 accepted pixels, then start again:
//    -> win_valid=0 and busy=0 the cycle after reset; no frame_done pulse;
//    -> second frame behaves as scenario 1.
//  6 Random in_valid gaps plus random out_ready: 64 windows; the (win_row, win_col) sequence
//    is raster order (1,1)..(8,8) with no gaps, compared against a scoreboard.

Source files
------------

// File: rtl/window_ctrl_pkg.sv
// Shared types and helpers for the 3x3 window scan controller.
package window_ctrl_pkg;

  // Default frame geometry for the Sobel front end.
  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_ROW_SIZE    = 10;
  localparam int DEF_NUM_ROWS    = 10;
  localparam int DEF_BUFFER_SIZE = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  // Counter width able to hold 0..n-1 (at least one bit).
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Distance from the newest pixel of a window to its centre, per axis.
  function automatic int centre_off(input int b);
    return (b - 1) / 2;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MAX counter with synchronous clear and a wrap strobe.
// wrap is high in the cycle where an enabled count leaves MAX-1.
module mod_counter
  import window_ctrl_pkg::*;
#(
  parameter int MAX = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  output logic [cnt_w(MAX)-1:0] count,
  output logic                  wrap
);

  localparam int W = cnt_w(MAX);
  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] r_count;

  assign count = r_count;
  assign wrap  = en & (r_count == LAST);

  // Count enabled events, restarting at zero on clear or after MAX-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : (r_count + W'(1));
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the sliding-window line buffer feeding the Sobel
// stage: forwards pixels with a shift strobe, tracks raster position,
// flags complete windows and brackets each frame with clear/done.
module window_scan_ctrl
  import window_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = DEF_WORD_SIZE,
  parameter int ROW_SIZE    = DEF_ROW_SIZE,
  parameter int NUM_ROWS    = DEF_NUM_ROWS,
  parameter int BUFFER_SIZE = DEF_BUFFER_SIZE
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_SIZE-1:0]       in_pixel,
  output logic [WORD_SIZE-1:0]       px_out,
  output logic                       shift_en,
  output logic                       clear_window,
  input  logic                       out_ready,
  output logic                       win_valid,
  output logic [cnt_w(NUM_ROWS)-1:0] win_row,
  output logic [cnt_w(ROW_SIZE)-1:0] win_col,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int ROW_W = cnt_w(NUM_ROWS);
  localparam int COL_W = cnt_w(ROW_SIZE);

  // First row/column at which the window is fully populated.
  localparam logic [ROW_W-1:0] ROW_QUAL = ROW_W'(BUFFER_SIZE - 1);
  localparam logic [COL_W-1:0] COL_QUAL = COL_W'(BUFFER_SIZE - 1);
  // Newest pixel sits (BUFFER_SIZE-1)/2 past the window centre.
  localparam logic [ROW_W-1:0] ROW_OFF  = ROW_W'(centre_off(BUFFER_SIZE));
  localparam logic [COL_W-1:0] COL_OFF  = COL_W'(centre_off(BUFFER_SIZE));

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic             r_clear;
  logic             r_frame_done;
  logic             r_win_valid;
  logic [ROW_W-1:0] r_win_row;
  logic [COL_W-1:0] r_win_col;

  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_col_wrap;
  logic             w_row_wrap;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_qualify;
  logic             w_start;
  logic             w_frame_end;

  // A new frame only begins from IDLE; start elsewhere is ignored.
  assign w_start     = (r_state == IDLE) & start;
  // Stall while the window is being cleared or an unconsumed window would be overwritten.
  assign w_in_ready  = ((r_state == FILL) | (r_state == RUN)) & ~r_clear
                       & (~r_win_valid | out_ready);
  assign w_accept    = in_valid & w_in_ready;
  // Both axes past the fill margin: no border window and no row-wrap straddle.
  assign w_qualify   = (w_row >= ROW_QUAL) & (w_col >= COL_QUAL);
  assign w_frame_end = (r_state == DONE) & ~r_win_valid;

  mod_counter #(.MAX(ROW_SIZE)) u_col_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start),
    .en    (w_accept),
    .count (w_col),
    .wrap  (w_col_wrap)
  );

  // Row wrap only fires on the last pixel of the frame, so it marks frame end.
  mod_counter #(.MAX(NUM_ROWS)) u_row_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_start),
    .en    (w_col_wrap),
    .count (w_row),
    .wrap  (w_row_wrap)
  );

  assign px_out       = in_pixel;
  assign shift_en     = w_accept;
  assign in_ready     = w_in_ready;
  assign clear_window = r_clear;
  assign frame_done   = r_frame_done;
  assign win_valid    = r_win_valid;
  assign win_row      = r_win_row;
  assign win_col      = r_win_col;
  assign busy         = (r_state != IDLE);

  // Next-state decode for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = FILL;
        else       w_state_nxt = IDLE;
      end
      FILL: begin
        if (w_row_wrap)                w_state_nxt = DONE;
        else if (w_accept & w_qualify) w_state_nxt = RUN;
        else                           w_state_nxt = FILL;
      end
      RUN: begin
        if (w_row_wrap) w_state_nxt = DONE;
        else            w_state_nxt = RUN;
      end
      DONE: begin
        if (!r_win_valid) w_state_nxt = IDLE;
        else              w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus the one-cycle clear and done pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_clear      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clear      <= w_start;
      r_frame_done <= w_frame_end;
    end
  end

  // Window flag and centre coordinates, one cycle behind the qualifying accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else if (w_accept & w_qualify) begin
      r_win_valid <= 1'b1;
      r_win_row   <= w_row - ROW_OFF;
      r_win_col   <= w_col - COL_OFF;
    end else if (out_ready) begin
      r_win_valid <= 1'b0;
      r_win_row   <= r_win_row;
      r_win_col   <= r_win_col;
    end else begin
      r_win_valid <= r_win_valid;
      r_win_row   <= r_win_row;
      r_win_col   <= r_win_col;
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with a 10x10 frame and 3x3 window.
module tb_window_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = 8'd0;
  logic [7:0] px_out;
  logic       shift_en;
  logic       clear_window;
  logic       out_ready = 1'b1;
  logic       win_valid;
  logic [3:0] win_row;
  logic [3:0] win_col;
  logic       busy;
  logic       frame_done;

  always #5 clk = ~clk;

  window_scan_ctrl #(
    .WORD_SIZE(8), .ROW_SIZE(10), .NUM_ROWS(10), .BUFFER_SIZE(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_pixel(in_pixel), .px_out(px_out),
    .shift_en(shift_en), .clear_window(clear_window), .out_ready(out_ready),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .busy(busy), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observations gathered by the cycle driver.
  int   n_clear, n_fdone, n_win, n_accept, prev_idx;
  int   first_acc, first_r, first_c;
  bit   seen_first;
  int   q_row[$];
  int   q_col[$];
  logic wv_after[100];
  int   wr_after[100];
  int   wc_after[100];
  logic s_in_ready, s_shift, s_wv, s_busy, s_fd;
  int   s_wr, s_wc;

  task automatic clr_mon();
    n_clear = 0; n_fdone = 0; n_win = 0; n_accept = 0; prev_idx = -1;
    first_acc = -1; first_r = -1; first_c = -1; seen_first = 1'b0;
    q_row.delete(); q_col.delete();
    for (int i = 0; i < 100; i++) begin
      wv_after[i] = 1'bx; wr_after[i] = -1; wc_after[i] = -1;
    end
  endtask

  // One clock: drive inputs, sample at the falling edge, advance past the rising edge.
  task automatic cyc(input logic v, input logic r, input logic st);
    in_valid  = v;
    out_ready = r;
    start     = st;
    in_pixel  = 8'($urandom);
    #4;
    s_in_ready = in_ready; s_shift = shift_en; s_wv = win_valid;
    s_busy = busy; s_fd = frame_done; s_wr = int'(win_row); s_wc = int'(win_col);
    if (clear_window) n_clear++;
    if (frame_done) n_fdone++;
    if (win_valid && !seen_first) begin
      seen_first = 1'b1; first_acc = n_accept;
      first_r = int'(win_row); first_c = int'(win_col);
    end
    if (win_valid && out_ready) begin
      n_win++; q_row.push_back(int'(win_row)); q_col.push_back(int'(win_col));
    end
    if (prev_idx >= 0 && prev_idx < 100) begin
      wv_after[prev_idx] = win_valid;
      wr_after[prev_idx] = int'(win_row);
      wc_after[prev_idx] = int'(win_col);
    end
    if (shift_en) begin prev_idx = n_accept; n_accept++; end
    else prev_idx = -1;
    @(posedge clk); #1;
  endtask

  // Run until frame_done is seen. vmode/rmode 1 = random gaps; stmode 1 = stray starts.
  task automatic finish_frame(input int vmode, input int rmode, input int stmode,
                              input int budget, output bit timeout);
    bit done = 1'b0;
    bit mid_sent = 1'b0;
    bit done_sent = 1'b0;
    logic v, r, st;
    for (int i = 0; i < budget && !done; i++) begin
      v  = (vmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      r  = (rmode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      st = 1'b0;
      if (stmode == 1 && !mid_sent && n_accept == 50) begin st = 1'b1; mid_sent = 1'b1; end
      if (stmode == 1 && !done_sent && n_accept == 100) begin st = 1'b1; done_sent = 1'b1; end
      cyc(v, r, st);
      if (s_fd) done = 1'b1;
    end
    timeout = !done;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; start = 1'b0; in_pixel = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (shift_en !== 1'b0)     begin n_err++; $display("FAIL rst_shift_en got %b exp 0", shift_en); end
    n_cmp++; if (win_valid !== 1'b0)    begin n_err++; $display("FAIL rst_win_valid got %b exp 0", win_valid); end
    n_cmp++; if (busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (frame_done !== 1'b0)   begin n_err++; $display("FAIL rst_frame_done got %b exp 0", frame_done); end
    n_cmp++; if (clear_window !== 1'b0) begin n_err++; $display("FAIL rst_clear got %b exp 0", clear_window); end
    n_cmp++; if (win_row !== 4'd0 || win_col !== 4'd0)
      begin n_err++; $display("FAIL rst_win_pos got %0d,%0d exp 0,0", win_row, win_col); end
    n_cmp++; if (px_out !== 8'hA5)      begin n_err++; $display("FAIL px_passthru got %h exp a5", px_out); end
    reset = 1'b0;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b0);
    n_cmp++; if (s_in_ready !== 1'b0)   begin n_err++; $display("FAIL idle_in_ready got %b exp 0", s_in_ready); end
    n_cmp++; if (n_accept !== 0)        begin n_err++; $display("FAIL idle_accept got %0d exp 0", n_accept); end
  endtask

  task automatic test_full_frame();
    bit to;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    n_cmp++; if (clear_window !== 1'b1) begin n_err++; $display("FAIL ff_clear_first got %b exp 1", clear_window); end
    n_cmp++; if (in_ready !== 1'b0)     begin n_err++; $display("FAIL ff_ready_in_clear got %b exp 0", in_ready); end
    n_cmp++; if (busy !== 1'b1)         begin n_err++; $display("FAIL ff_busy got %b exp 1", busy); end
    finish_frame(0, 0, 0, 400, to);
    n_cmp++; if (to)                    begin n_err++; $display("FAIL ff_timeout got timeout exp frame_done"); end
    n_cmp++; if (n_clear !== 1)         begin n_err++; $display("FAIL ff_clear_count got %0d exp 1", n_clear); end
    n_cmp++; if (first_acc !== 23)      begin n_err++; $display("FAIL ff_first_latency got %0d exp 23", first_acc); end
    n_cmp++; if (first_r !== 1 || first_c !== 1)
      begin n_err++; $display("FAIL ff_first_pos got %0d,%0d exp 1,1", first_r, first_c); end
    n_cmp++; if (n_win !== 64)          begin n_err++; $display("FAIL ff_windows got %0d exp 64", n_win); end
    n_cmp++; if (n_accept !== 100)      begin n_err++; $display("FAIL ff_accepts got %0d exp 100", n_accept); end
    n_cmp++; if (n_fdone !== 1)         begin n_err++; $display("FAIL ff_done_count got %0d exp 1", n_fdone); end
    n_cmp++; if (busy !== 1'b0 || frame_done !== 1'b0)
      begin n_err++; $display("FAIL ff_end_state got busy=%b done=%b exp 0,0", busy, frame_done); end
  endtask

  task automatic test_row_wrap();
    bit to;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    finish_frame(0, 0, 0, 400, to);
    n_cmp++; if (to)                  begin n_err++; $display("FAIL rw_timeout got timeout exp frame_done"); end
    n_cmp++; if (wv_after[21] !== 1'b0) begin n_err++; $display("FAIL rw_r2c1 got %b exp 0", wv_after[21]); end
    n_cmp++; if (wv_after[29] !== 1'b1 || wr_after[29] !== 1 || wc_after[29] !== 8)
      begin n_err++; $display("FAIL rw_r2c9 got %b %0d,%0d exp 1 1,8", wv_after[29], wr_after[29], wc_after[29]); end
    n_cmp++; if (wv_after[30] !== 1'b0) begin n_err++; $display("FAIL rw_r3c0 got %b exp 0", wv_after[30]); end
    n_cmp++; if (wv_after[31] !== 1'b0) begin n_err++; $display("FAIL rw_r3c1 got %b exp 0", wv_after[31]); end
    n_cmp++; if (wv_after[32] !== 1'b1 || wr_after[32] !== 2 || wc_after[32] !== 1)
      begin n_err++; $display("FAIL rw_r3c2 got %b %0d,%0d exp 1 2,1", wv_after[32], wr_after[32], wc_after[32]); end
  endtask

  task automatic test_backpressure();
    bit to;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200 && n_accept < 45; i++) cyc(1'b1, 1'b1, 1'b0);
    for (int h = 0; h < 5; h++) begin
      cyc(1'b1, 1'b0, 1'b0);
      n_cmp++; if (s_wv !== 1'b1)       begin n_err++; $display("FAIL bp_hold_valid[%0d] got %b exp 1", h, s_wv); end
      n_cmp++; if (s_in_ready !== 1'b0 || s_shift !== 1'b0)
        begin n_err++; $display("FAIL bp_stall[%0d] got rdy=%b shift=%b exp 0,0", h, s_in_ready, s_shift); end
      n_cmp++; if (s_wr !== 3 || s_wc !== 3)
        begin n_err++; $display("FAIL bp_hold_pos[%0d] got %0d,%0d exp 3,3", h, s_wr, s_wc); end
    end
    finish_frame(0, 0, 0, 400, to);
    n_cmp++; if (to)                  begin n_err++; $display("FAIL bp_timeout got timeout exp frame_done"); end
    n_cmp++; if (n_win !== 64)        begin n_err++; $display("FAIL bp_windows got %0d exp 64", n_win); end
    for (int i = 0; i < q_row.size() && i < 64; i++) begin
      n_cmp++;
      if (q_row[i] !== 1 + i / 8 || q_col[i] !== 1 + i % 8)
        begin n_err++; $display("FAIL bp_seq[%0d] got %0d,%0d exp %0d,%0d", i, q_row[i], q_col[i], 1 + i / 8, 1 + i % 8); end
    end
  endtask

  task automatic test_stray_start();
    bit to;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    finish_frame(0, 0, 1, 400, to);
    n_cmp++; if (to)                  begin n_err++; $display("FAIL ss_timeout got timeout exp frame_done"); end
    n_cmp++; if (n_win !== 64)        begin n_err++; $display("FAIL ss_windows got %0d exp 64", n_win); end
    n_cmp++; if (n_accept !== 100)    begin n_err++; $display("FAIL ss_accepts got %0d exp 100", n_accept); end
    n_cmp++; if (n_clear !== 1)       begin n_err++; $display("FAIL ss_clear_count got %0d exp 1", n_clear); end
    n_cmp++; if (n_fdone !== 1)       begin n_err++; $display("FAIL ss_done_count got %0d exp 1", n_fdone); end
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (s_busy !== 1'b0)     begin n_err++; $display("FAIL ss_idle_after got busy=%b exp 0", s_busy); end
  endtask

  task automatic test_mid_reset();
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 200 && n_accept < 40; i++) cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    reset = 1'b0;
    clr_mon();
    cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (s_wv !== 1'b0)       begin n_err++; $display("FAIL mr_win_valid got %b exp 0", s_wv); end
    n_cmp++; if (s_busy !== 1'b0)     begin n_err++; $display("FAIL mr_busy got %b exp 0", s_busy); end
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    n_cmp++; if (n_fdone !== 0)       begin n_err++; $display("FAIL mr_no_done got %0d exp 0", n_fdone); end
    test_full_frame();
  endtask

  task automatic test_random();
    bit to;
    clr_mon();
    cyc(1'b1, 1'b1, 1'b1);
    finish_frame(1, 1, 0, 3000, to);
    n_cmp++; if (to)                  begin n_err++; $display("FAIL rnd_timeout got timeout exp frame_done"); end
    n_cmp++; if (n_win !== 64)        begin n_err++; $display("FAIL rnd_windows got %0d exp 64", n_win); end
    n_cmp++; if (n_fdone !== 1)       begin n_err++; $display("FAIL rnd_done_count got %0d exp 1", n_fdone); end
    for (int i = 0; i < q_row.size() && i < 64; i++) begin
      n_cmp++;
      if (q_row[i] !== 1 + i / 8 || q_col[i] !== 1 + i % 8)
        begin n_err++; $display("FAIL rnd_seq[%0d] got %0d,%0d exp %0d,%0d", i, q_row[i], q_col[i], 1 + i / 8, 1 + i % 8); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_row_wrap();
    test_backpressure();
    test_stray_start();
    test_mid_reset();
    test_random();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
